// File: rtl/fa_vector_sequencer.sv
// fa_vector_sequencer
// Exhaustive self-checking stimulus controller for a 1-bit full adder.
// A start request in IDLE launches a run. The run drives all eight
// {carry-in, B, A} combinations in binary order. Each vector is held for
// HOLD_CYCLES cycles. The adder's sum/carry are compared against the golden
// full-adder function on the last hold cycle of each vector.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          launch a run (only honoured in IDLE)
//   abort          cancel the run in progress (only honoured while driving)
//   sum_in         sum output of the adder under test
//   cout_in        carry output of the adder under test
//   out1/out2/out3 adder A / B / carry-in (vector bits 0/1/2), registered
//   busy           high while vectors are being driven
//   done           one-cycle pulse when a run completes normally
//   pass           last completed run saw no mismatches
//   err_cnt        saturating count of mismatching vectors
//   first_fail     index {out3,out2,out1} of the first mismatching vector
//   first_fail_vld first_fail holds a valid index
module fa_vector_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sum_in,
  input  logic             cout_in,
  output logic             out1,
  output logic             out2,
  output logic             out3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail,
  output logic             first_fail_vld
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [2:0]       r_vec;
  logic [2:0]       r_out;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_firstFail;
  logic             r_firstFailVld;

  logic             w_expSum;
  logic             w_expCout;
  logic             w_mismatch;
  logic             w_lastHold;
  logic [ERR_W-1:0] w_errNext;

  // Golden model is evaluated on the registered vector the adder is
  // actually seeing, so the comparison matches what was driven.
  always_comb begin
    w_expSum   = r_out[0] ^ r_out[1] ^ r_out[2];
    w_expCout  = (r_out[0] & r_out[1]) | (r_out[0] & r_out[2]) | (r_out[1] & r_out[2]);
    w_mismatch = (sum_in != w_expSum) || (cout_in != w_expCout);
    w_lastHold = (r_hold == HW'(HOLD_CYCLES - 1));
    // Saturate rather than wrap so a large failure count never reads as small.
    w_errNext  = r_err;
    if (w_mismatch && (r_err != {ERR_W{1'b1}})) begin
      w_errNext = r_err + ERR_W'(1);
    end
  end

  // Single sequencer FSM; every output is a register updated here.
  // abort is tested before the hold/check logic so a same-edge check is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hold         <= '0;
      r_vec          <= '0;
      r_out          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_err          <= '0;
      r_firstFail    <= '0;
      r_firstFailVld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_DRIVE;
            r_vec          <= '0;
            r_hold         <= '0;
            r_out          <= '0;
            r_busy         <= 1'b1;
            r_pass         <= 1'b0;
            r_err          <= '0;
            r_firstFail    <= '0;
            r_firstFailVld <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_out   <= '0;
            r_vec   <= '0;
            r_hold  <= '0;
          end else if (w_lastHold) begin
            r_err <= w_errNext;
            if (w_mismatch && !r_firstFailVld) begin
              r_firstFail    <= r_out;
              r_firstFailVld <= 1'b1;
            end
            r_hold <= '0;
            if (r_vec == 3'd7) begin
              // pass must include the check made on this same edge.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_errNext == '0);
              r_out   <= '0;
              r_vec   <= '0;
            end else begin
              r_vec <= r_vec + 3'd1;
              r_out <= r_vec + 3'd1;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out1           = r_out[0];
  assign out2           = r_out[1];
  assign out3           = r_out[2];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_fail     = r_firstFail;
  assign first_fail_vld = r_firstFailVld;

endmodule

// File: tb/tb_fa_vector_sequencer.sv
// Directed testbench for fa_vector_sequencer.
// A behavioural full adder with selectable faults closes the loop around the
// main instance (HOLD_CYCLES=2, ERR_W=4). A second instance with ERR_W=2 is
// wired to an adder with both outputs inverted, which exercises saturation.
module tb_fa_vector_sequencer;

  logic       clock;
  logic       rst;
  logic       start;
  logic       abort;
  logic       sumIn;
  logic       coutIn;
  logic       out1, out2, out3;
  logic       busy, done, pass;
  logic [3:0] errCnt;
  logic [2:0] firstFail;
  logic       firstFailVld;

  logic       start2;
  logic       sumIn2, coutIn2;
  logic       o1b, o2b, o3b;
  logic       busy2, done2, pass2;
  logic [1:0] errCnt2;
  logic [2:0] firstFail2;
  logic       firstFailVld2;

  int faultMode;
  int nCompared;
  int nMismatched;

  fa_vector_sequencer #(.HOLD_CYCLES(2), .ERR_W(4)) dut (
    .clk(clock), .rst(rst), .start(start), .abort(abort),
    .sum_in(sumIn), .cout_in(coutIn),
    .out1(out1), .out2(out2), .out3(out3),
    .busy(busy), .done(done), .pass(pass), .err_cnt(errCnt),
    .first_fail(firstFail), .first_fail_vld(firstFailVld)
  );

  fa_vector_sequencer #(.HOLD_CYCLES(2), .ERR_W(2)) dutSat (
    .clk(clock), .rst(rst), .start(start2), .abort(abort),
    .sum_in(sumIn2), .cout_in(coutIn2),
    .out1(o1b), .out2(o2b), .out3(o3b),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2),
    .first_fail(firstFail2), .first_fail_vld(firstFailVld2)
  );

  // Clock: 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Adder under test: mode 0 correct, mode 1 sum stuck-at-0.
  always_comb begin
    sumIn  = out1 ^ out2 ^ out3;
    coutIn = (out1 & out2) | (out1 & out3) | (out2 & out3);
    if (faultMode == 1) sumIn = 1'b0;
  end

  // Second adder: both outputs inverted, so every vector mismatches.
  always_comb begin
    sumIn2  = ~(o1b ^ o2b ^ o3b);
    coutIn2 = ~((o1b & o2b) | (o1b & o3b) | (o2b & o3b));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge (E0); returns positioned in cycle 1 after E0.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walk cycles 1..16 of a run checking the vector and busy each cycle.
  // An optional extra start is raised in cycle midStart to show it is ignored.
  // Returns positioned in cycle 17 (the done cycle).
  task automatic checkRunBody(input int midStart);
    for (int c = 1; c <= 16; c++) begin
      checkOutput($sformatf("vec_c%0d", c), {29'd0, out3, out2, out1}, (c - 1) / 2);
      checkOutput($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("done_c%0d", c), {31'd0, done}, 32'd0);
      start = (c == midStart);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic checkResults(input string tag, input logic d, input logic p,
                              input logic [3:0] e, input logic [2:0] ff, input logic v);
    checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, d});
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    checkOutput({tag, "_err"}, {28'd0, errCnt}, {28'd0, e});
    checkOutput({tag, "_ff"}, {29'd0, firstFail}, {29'd0, ff});
    checkOutput({tag, "_ffv"}, {31'd0, firstFailVld}, {31'd0, v});
    checkOutput({tag, "_outs"}, {29'd0, out3, out2, out1}, 32'd0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    faultMode   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    abort  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("[TB] reset state");
    checkResults("reset", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);

    $display("[TB] test 1: correct adder");
    applyStimulus();
    checkRunBody(0);
    checkResults("t1", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
    tick();
    checkOutput("t1_done_gone", {31'd0, done}, 32'd0);
    checkOutput("t1_pass_held", {31'd0, pass}, 32'd1);

    $display("[TB] test 2: sum stuck-at-0");
    faultMode = 1;
    applyStimulus();
    checkRunBody(0);
    checkResults("t2", 1'b1, 1'b0, 4'd4, 3'd1, 1'b0 | 1'b1);
    tick();
    tick();
    checkOutput("t2_err_held", {28'd0, errCnt}, 32'd4);

    $display("[TB] test 4: restart clears results, mid-run start ignored");
    faultMode = 0;
    applyStimulus();
    checkOutput("t4_err_clr", {28'd0, errCnt}, 32'd0);
    checkOutput("t4_ffv_clr", {31'd0, firstFailVld}, 32'd0);
    checkOutput("t4_ff_clr", {29'd0, firstFail}, 32'd0);
    checkRunBody(5);
    checkResults("t4", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
    tick();
    applyStimulus();
    checkOutput("t4b_busy", {31'd0, busy}, 32'd1);
    checkOutput("t4b_pass_clr", {31'd0, pass}, 32'd0);
    checkRunBody(0);
    checkResults("t4b", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
    tick();

    $display("[TB] test 5: abort during vector 3");
    faultMode = 1;
    applyStimulus();
    for (int c = 1; c < 7; c++) tick();
    checkOutput("t5_vec3", {29'd0, out3, out2, out1}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkResults("t5", 1'b0, 1'b0, 4'd2, 3'd1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      checkOutput("t5_no_done", {31'd0, done}, 32'd0);
      tick();
    end

    $display("[TB] test 5b: abort on a check edge drops that check");
    applyStimulus();
    for (int c = 1; c < 4; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkResults("t5b", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
    tick();

    $display("[TB] test 6: reset during vector 5");
    applyStimulus();
    for (int c = 1; c < 11; c++) tick();
    checkOutput("t6_vec5", {29'd0, out3, out2, out1}, 32'd5);
    checkOutput("t6_err_pre", {28'd0, errCnt}, 32'd3);
    rst   = 1'b1;
    abort = 1'b1;
    tick();
    rst   = 1'b0;
    abort = 1'b0;
    checkResults("t6", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
    faultMode = 0;
    tick();
    applyStimulus();
    checkRunBody(0);
    checkResults("t6_rerun", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
    tick();

    $display("[TB] test 3: ERR_W=2 saturation");
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c < 17; c++) begin
      if (c == 9) checkOutput("t3_err_mid", {30'd0, errCnt2}, 32'd3);
      tick();
    end
    checkOutput("t3_done", {31'd0, done2}, 32'd1);
    checkOutput("t3_pass", {31'd0, pass2}, 32'd0);
    checkOutput("t3_err", {30'd0, errCnt2}, 32'd3);
    checkOutput("t3_ff", {29'd0, firstFail2}, 32'd0);
    checkOutput("t3_ffv", {31'd0, firstFailVld2}, 32'd1);
    checkOutput("t3_busy", {31'd0, busy2}, 32'd0);
    checkOutput("t3_outs", {29'd0, o3b, o2b, o1b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fa_vector_sequencer.md
Name: fa_vector_sequencer

Overview:
- Synthesizable exhaustive-test controller for the 1-bit full-adder datapath.
- On `start`, it drives all 8 input combinations onto `out1`/`out2`/`out3` and holds each for a programmable number of cycles.
- It samples the adder's `sum`/`cout` and compares them against the golden values, counting mismatches and recording the first failing vector.
- Sits between a host/bench control register and the full-adder instance; it replaces open-loop timed stimulus with a clocked, self-checking sequence.

Parameters:
HOLD_CYCLES, 2, cycles each vector is driven before it is checked; legal range >=1.
ERR_W, 4, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a test run; sampled only in IDLE
abort  input  1  terminate the run in progress; sampled only while busy
sum_in  input  1  sum output of the full adder under test
cout_in  input  1  carry output of the full adder under test
out1  output  1  adder input A, vector bit 0 (registered)
out2  output  1  adder input B, vector bit 1 (registered)
out3  output  1  adder carry-in, vector bit 2 (registered)
busy  output  1  high while in DRIVE
done  output  1  one-cycle pulse on normal completion
pass  output  1  high when the last completed run had zero mismatches
err_cnt  output  ERR_W  mismatch count of the current/last run
first_fail  output  3  index {out3,out2,out1} of the first mismatching vector
first_fail_vld  output  1  first_fail holds a valid index

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all outputs 0; hold counter and vector index 0. Reset applies from any state, mid-run included.
- States:
  - IDLE: `start`=1 → DRIVE with vec=0, hold=0; clear err_cnt, pass, first_fail, first_fail_vld.
  - DRIVE: busy=1; {out3,out2,out1}=vec. `hold` increments each cycle.
    - On the edge where hold==HOLD_CYCLES-1, sample sum_in/cout_in.
    - Then, if vec==7 → DONE; else vec+1 and hold=0.
  - DONE: one cycle; done=1, busy=0; pass=(err_cnt==0 including final check) → IDLE.
- Vector order: 0,1,...,7, binary count with out1 as LSB. Wrap-around is not allowed: the run ends after vector 7.
- Golden model:
  - expected sum = out1^out2^out3
  - expected cout = majority(out1,out2,out3)
  - A mismatch on either or both bits counts as one error per vector.
- err_cnt increments on each mismatching vector and saturates at all-ones; it never wraps.
- first_fail/first_fail_vld are written on the first mismatch only, then held.
- Latency: the accepting edge is E0. Vector k is driven during cycles k*HOLD_CYCLES+1 .. (k+1)*HOLD_CYCLES after E0. done is high in cycle 8*HOLD_CYCLES+1 after E0. busy is high for exactly 8*HOLD_CYCLES cycles.
- start while busy or in DONE: ignored, not queued.
- abort=1 in DRIVE:
  - Next state is IDLE, done is not pulsed, pass=0.
  - err_cnt and first_fail keep their partial values.
  - out1..3 return to 0.
  - abort has priority over a same-edge check/advance: the check in that cycle is discarded.
- abort outside DRIVE: no effect.
- rst and abort together: rst wins, giving the full reset state.
- Result outputs (pass, err_cnt, first_fail*) are stable from DONE until the next accepted start.
- out1..3 are 0 in IDLE and DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Correct full adder, HOLD_CYCLES=2, start pulse → out vectors step 0..7 every 2 cycles; done at cycle 17 after E0; pass=1, err_cnt=0, first_fail_vld=0.
2. sum_in stuck-at-0 → mismatches at vectors 1,2,4,7; err_cnt=4, first_fail=1, first_fail_vld=1, pass=0.
3. ERR_W=2, sum and cout both inverted → 8 mismatches; err_cnt saturates at 3, first_fail=0, pass=0.
4. Re-assert start mid-run at cycle 5 → ignored; run completes normally at cycle 17 with unchanged results. A second start in IDLE after done → results cleared at the accepting edge and a new run begins.
5. abort during vector 3 with sum_in stuck-at-0 → IDLE next cycle; no done pulse; pass=0; err_cnt=2; first_fail=1; out1..3=0.
6. rst asserted during vector 5 → next cycle: all outputs 0, state IDLE; subsequent start runs a clean 16-cycle sequence.
